// File: rtl/tuner_pkt_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tuner_pkt_arbiter_pkg
//   Shared constants for the tuner packet arbiter: default packet geometry,
//   FX2 slave-FIFO constants, the FSM state encoding and a small helper for
//   advancing the round-robin pointer.
// ----------------------------------------------------------------------------
package tuner_pkt_arbiter_pkg;

    localparam int PKT_LEN_DEF = 188;   // bytes per TS packet
    localparam int PID_W_DEF   = 12;    // PID index width
    localparam int SEL_W       = 2;     // tuner select / round-robin pointer width
    localparam int RADD_W      = 9;     // {half, byte[7:0]}

    // FX2 endpoint address driven on fadd
    localparam logic [1:0] FADD_EP = 2'b01;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Pointer to the tuner after cur, wrapping n-1 -> 0
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] cur, input int n);
        if (int'(cur) >= n - 1) begin
            return '0;
        end
        return cur + SEL_W'(1);
    endfunction

endpackage

// File: rtl/tuner_pkt_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tuner_pkt_arbiter_rr_arbiter
//   Combinational round-robin picker: grants the first asserted request at or
//   after the pointer, searching upward and wrapping.
// Ports
//   req_i      N     request vector
//   ptr_i      2     search start index (must be < N)
//   gnt_o      N     one-hot grant (zero when no request)
//   gnt_idx_o  2     index of the granted request
//   gnt_vld_o  1     any request granted
// ----------------------------------------------------------------------------
module tuner_pkt_arbiter_rr_arbiter
    import tuner_pkt_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    always_comb begin : pick
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tuner_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// tuner_pkt_arbiter
//   Schedules PKT_LEN-byte TS packets from NUM_TUNER ping-pong buffers onto
//   the FX2 slave-FIFO write port. Rising edges of req_i are latched as
//   pending requests, served round-robin; the granted half-buffer is read
//   byte by byte and written with pktstart/pktend framing, stalling on full.
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   req_i/buf_h_i   per-tuner packet-ready level and half-buffer select
//   pid_i           per-tuner PID index of the ready packet
//   db_out_i        per-tuner buffer RAM read data (registered read)
//   db_radd_en/db_radd/db_rsel   RAM read enable, address, tuner select
//   rel_o           1-cycle pulse: half-buffer fully sent
//   ovf_o           sticky: request arrived while already pending
//   flaga/flagb     FX2 flags (flagb = not full; flaga unused)
//   fadd/sloe/slrd  FX2 constants
//   slwr/data_out   active-low write strobe and write data
//   pktstart_o/pktend_o  active-low framing, coincident with first/last byte
//   pid_idx/mrxdv   PID of packet in flight, packet-in-flight flag
// ----------------------------------------------------------------------------
module tuner_pkt_arbiter
    import tuner_pkt_arbiter_pkg::*;
#(
    parameter int NUM_TUNER = 3,
    parameter int PKT_LEN   = PKT_LEN_DEF,
    parameter int PID_W     = PID_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_TUNER-1:0]       req_i,
    input  logic [NUM_TUNER-1:0]       buf_h_i,
    input  logic [NUM_TUNER*PID_W-1:0] pid_i,
    input  logic [NUM_TUNER*8-1:0]     db_out_i,
    output logic                       db_radd_en,
    output logic [RADD_W-1:0]          db_radd,
    output logic [SEL_W-1:0]           db_rsel,
    output logic [NUM_TUNER-1:0]       rel_o,
    output logic [NUM_TUNER-1:0]       ovf_o,
    input  logic                       flaga,
    input  logic                       flagb,
    output logic [1:0]                 fadd,
    output logic                       sloe,
    output logic                       slrd,
    output logic                       slwr,
    output logic [7:0]                 data_out,
    output logic                       pktstart_o,
    output logic                       pktend_o,
    output logic [PID_W-1:0]           pid_idx,
    output logic                       mrxdv
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    // flaga is part of the pinout only
    logic unused_flaga;
    assign unused_flaga = flaga;

    logic fifo_full;
    assign fifo_full = ~flagb;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    logic [NUM_TUNER-1:0] req_q;
    logic [NUM_TUNER-1:0] rise;
    logic [NUM_TUNER-1:0] pend_vec;
    logic [NUM_TUNER-1:0] bufh_vec;
    logic [PID_W-1:0]     pid_lat [NUM_TUNER];
    logic [NUM_TUNER-1:0] take;

    assign rise = req_i & ~req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    for (genvar gi = 0; gi < NUM_TUNER; gi++) begin : g_cap
        logic             pend_q;
        logic             bufh_q;
        logic             ovf_q;
        logic [PID_W-1:0] pid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pend_q <= 1'b0;
                bufh_q <= 1'b0;
                ovf_q  <= 1'b0;
                pid_q  <= '0;
            end else if (rise[gi]) begin
                // a new edge wins over a same-cycle grant; the newer packet overwrites
                pend_q <= 1'b1;
                bufh_q <= buf_h_i[gi];
                pid_q  <= pid_i[gi*PID_W +: PID_W];
                if (pend_q && !take[gi]) begin
                    ovf_q <= 1'b1;
                end
            end else if (take[gi]) begin
                pend_q <= 1'b0;
            end
        end

        assign pend_vec[gi] = pend_q;
        assign bufh_vec[gi] = bufh_q;
        assign ovf_o[gi]    = ovf_q;
        assign pid_lat[gi]  = pid_q;
    end

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]     rr_ptr_q;
    logic [NUM_TUNER-1:0] gnt_oh;
    logic [SEL_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic [1:0]           state_q;

    tuner_pkt_arbiter_rr_arbiter #(
        .N (NUM_TUNER)
    ) u_rr (
        .req_i     (pend_vec),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign take = gnt_oh & {NUM_TUNER{state_q == ST_IDLE}};

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    logic [RADD_W-1:0]    radd_q;
    logic [SEL_W-1:0]     sel_q;
    logic [PID_W-1:0]     pid_idx_q;
    logic                 mrxdv_q;
    logic [NUM_TUNER-1:0] rel_q;
    logic                 hold_q;
    logic                 pktend_q;

    // A held byte blocks further reads so at most one byte is ever parked
    assign db_radd_en = (state_q == ST_READ) && !fifo_full && !hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            radd_q    <= '0;
            sel_q     <= '0;
            pid_idx_q <= '0;
            mrxdv_q   <= 1'b0;
            rel_q     <= '0;
        end else begin
            rel_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        state_q   <= ST_READ;
                        sel_q     <= gnt_idx;
                        radd_q    <= {bufh_vec[gnt_idx], 8'h00};
                        pid_idx_q <= pid_lat[gnt_idx];
                        mrxdv_q   <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (db_radd_en) begin
                        // stop on the last byte: the address never leaves the half-buffer
                        if (radd_q[7:0] == LAST_IDX) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            radd_q[7:0] <= radd_q[7:0] + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pktend_q) begin
                        rel_q[sel_q] <= 1'b1;
                        mrxdv_q      <= 1'b0;
                        rr_ptr_q     <= rr_next(sel_q, NUM_TUNER);
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO write path with single-byte hold
    // ------------------------------------------------------------------
    logic       rd_pend_q;
    logic [7:0] rd_idx_q;
    logic [7:0] hold_idx_q;
    logic [7:0] data_q;
    logic       slwr_q;
    logic       pktstart_q;
    logic [7:0] rd_byte;

    assign rd_byte = db_out_i[int'(sel_q)*8 +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            data_q     <= '0;
            slwr_q     <= 1'b1;
            pktstart_q <= 1'b1;
            pktend_q   <= 1'b1;
        end else begin
            rd_pend_q <= db_radd_en;
            rd_idx_q  <= radd_q[7:0];
            if (hold_q) begin
                // retry the parked byte; data_out already carries it
                if (!fifo_full) begin
                    hold_q     <= 1'b0;
                    slwr_q     <= 1'b0;
                    pktstart_q <= (hold_idx_q != 8'd0);
                    pktend_q   <= (hold_idx_q != LAST_IDX);
                end else begin
                    slwr_q     <= 1'b1;
                    pktstart_q <= 1'b1;
                    pktend_q   <= 1'b1;
                end
            end else if (rd_pend_q) begin
                data_q <= rd_byte;
                if (!fifo_full) begin
                    slwr_q     <= 1'b0;
                    pktstart_q <= (rd_idx_q != 8'd0);
                    pktend_q   <= (rd_idx_q != LAST_IDX);
                end else begin
                    hold_q     <= 1'b1;
                    hold_idx_q <= rd_idx_q;
                    slwr_q     <= 1'b1;
                    pktstart_q <= 1'b1;
                    pktend_q   <= 1'b1;
                end
            end else begin
                slwr_q     <= 1'b1;
                pktstart_q <= 1'b1;
                pktend_q   <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign db_radd    = radd_q;
    assign db_rsel    = sel_q;
    assign rel_o      = rel_q;
    assign fadd       = FADD_EP;
    assign sloe       = 1'b1;
    assign slrd       = 1'b1;
    assign slwr       = slwr_q;
    assign data_out   = data_q;
    assign pktstart_o = pktstart_q;
    assign pktend_o   = pktend_q;
    assign pid_idx    = pid_idx_q;
    assign mrxdv      = mrxdv_q;

endmodule

// File: tb/tb_tuner_pkt_arbiter.sv
module tb_tuner_pkt_arbiter;

    localparam int NT = 3;
    localparam int PL = 188;
    localparam int PW = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NT-1:0]    req_i = '0;
    logic [NT-1:0]    buf_h_i = '0;
    logic [NT*PW-1:0] pid_i = '0;
    logic [NT*8-1:0]  db_out_i = '0;
    logic             db_radd_en;
    logic [8:0]       db_radd;
    logic [1:0]       db_rsel;
    logic [NT-1:0]    rel_o;
    logic [NT-1:0]    ovf_o;
    logic             flaga = 1'b1;
    logic             flagb = 1'b1;
    logic [1:0]       fadd;
    logic             sloe;
    logic             slrd;
    logic             slwr;
    logic [7:0]       data_out;
    logic             pktstart_o;
    logic             pktend_o;
    logic [PW-1:0]    pid_idx;
    logic             mrxdv;

    tuner_pkt_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .buf_h_i    (buf_h_i),
        .pid_i      (pid_i),
        .db_out_i   (db_out_i),
        .db_radd_en (db_radd_en),
        .db_radd    (db_radd),
        .db_rsel    (db_rsel),
        .rel_o      (rel_o),
        .ovf_o      (ovf_o),
        .flaga      (flaga),
        .flagb      (flagb),
        .fadd       (fadd),
        .sloe       (sloe),
        .slrd       (slrd),
        .slwr       (slwr),
        .data_out   (data_out),
        .pktstart_o (pktstart_o),
        .pktend_o   (pktend_o),
        .pid_idx    (pid_idx),
        .mrxdv      (mrxdv)
    );

    always #5 clk = ~clk;

    // Buffer RAM model: one 512-byte RAM per tuner, registered read
    logic [7:0] mem [NT][512];
    always @(posedge clk) begin
        if (db_radd_en) begin
            for (int t = 0; t < NT; t++) begin
                db_out_i[t*8 +: 8] <= mem[t][db_radd];
            end
        end
    end

    // Counters
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending requests, latched pid/half, RR pointer
    bit            m_pend [NT];
    logic [PW-1:0] m_pid  [NT];
    bit            m_half [NT];
    int            m_ptr = 0;
    logic [NT-1:0] m_ovf = '0;

    // Scoreboard / monitor state
    bit in_pkt = 0;
    int cur_t = 0;
    int cur_idx = 0;
    bit cur_half = 0;
    bit rel_due = 0;
    int rel_t = 0;
    int pkt_cnt = 0;
    bit flagb_prev = 1;

    // Flag driver
    int fmode = 0;       // 0: always ready, 1: random, 2: toggle each clk
    int stall_cnt = 0;
    bit stall_arm = 0;

    always @(posedge clk) begin
        #1;
        case (fmode)
            1:       flagb = ($urandom_range(0, 3) != 0);
            2:       flagb = ~flagb;
            default: flagb = 1'b1;
        endcase
        if (stall_cnt > 0) begin
            flagb = 1'b0;
            stall_cnt--;
        end
    end

    function automatic int rr_pick();
        for (int k = 0; k < NT; k++) begin
            int t;
            t = (m_ptr + k) % NT;
            if (m_pend[t]) return t;
        end
        return -1;
    endfunction

    // Monitor: compares every DUT write against the model
    always @(negedge clk) begin
        if (rst) begin
            if (rel_due) begin
                logic [NT-1:0] e;
                e = '0;
                e[rel_t] = 1'b1;
                check("rel_pulse", rel_o, e);
                check("mrxdv_low_after", mrxdv, 0);
                rel_due = 0;
            end else if (rel_o != '0) begin
                n_total++;
                $display("FAIL rel_unexpected: got 0x%0h expected 0x0 at %0t", rel_o, $time);
            end
            if (!slwr) begin
                check("wr_after_notfull", flagb_prev, 1);
                if (!in_pkt) begin
                    int t;
                    t = rr_pick();
                    if (t < 0) begin
                        n_total++;
                        $display("FAIL write_without_request: got slwr=0 expected no write at %0t", $time);
                    end else begin
                        cur_t = t;
                        cur_half = m_half[t];
                        cur_idx = 0;
                        m_pend[t] = 0;
                        in_pkt = 1;
                        check("pid_idx", pid_idx, m_pid[t]);
                        check("db_rsel", db_rsel, t);
                        check("mrxdv_high", mrxdv, 1);
                    end
                end
                if (in_pkt) begin
                    check("data", data_out, mem[cur_t][{cur_half, 8'(cur_idx)}]);
                    check("pktstart", pktstart_o, (cur_idx != 0));
                    check("pktend", pktend_o, (cur_idx != PL - 1));
                    if (stall_arm && cur_idx == 48) begin
                        stall_cnt = 5;
                        stall_arm = 0;
                    end
                    cur_idx++;
                    if (cur_idx == PL) begin
                        $display("pkt %0d: tuner %0d half %0d pid 0x%03h bytes %0d",
                                 pkt_cnt, cur_t, cur_half, m_pid[cur_t], cur_idx);
                        pkt_cnt++;
                        in_pkt = 0;
                        rel_due = 1;
                        rel_t = cur_t;
                        m_ptr = (cur_t + 1) % NT;
                    end
                end
            end
        end
        flagb_prev = flagb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NT-1:0] mask, input logic [NT-1:0] halves,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [PW-1:0] p2);
        logic [PW-1:0] p [NT];
        p[0] = p0; p[1] = p1; p[2] = p2;
        for (int t = 0; t < NT; t++) begin
            if (mask[t]) begin
                buf_h_i[t] = halves[t];
                pid_i[t*PW +: PW] = p[t];
                if (m_pend[t]) m_ovf[t] = 1'b1;
                m_pend[t] = 1;
                m_pid[t]  = p[t];
                m_half[t] = halves[t];
            end
        end
        req_i = mask;
        tick();
        req_i = '0;
        tick();
    endtask

    function automatic bit model_busy();
        return in_pkt || rel_due || m_pend[0] || m_pend[1] || m_pend[2];
    endfunction

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (model_busy() && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            n_total++;
            $display("FAIL timeout_done: got busy after %0d clks expected idle", n);
        end
        tick();
    endtask

    task automatic wait_mid(input int t, input int b, input int maxc);
        int n;
        n = 0;
        while (!(in_pkt && cur_t == t && cur_idx >= b) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            n_total++;
            $display("FAIL timeout_mid: got no tuner %0d byte %0d expected within %0d clks", t, b, maxc);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_slwr", slwr, 1);
        check("rst_pktstart", pktstart_o, 1);
        check("rst_pktend", pktend_o, 1);
        check("rst_data_out", data_out, 0);
        check("rst_pid_idx", pid_idx, 0);
        check("rst_rel", rel_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_mrxdv", mrxdv, 0);
        check("rst_radd_en", db_radd_en, 0);
        check("fadd", fadd, 1);
        check("sloe", sloe, 1);
        check("slrd", slrd, 1);
    endtask

    // Asynchronous reset mid-cycle; model forgets everything in flight
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals();
        req_i = '0;
        for (int t = 0; t < NT; t++) m_pend[t] = 0;
        m_ptr = 0;
        m_ovf = '0;
        in_pkt = 0;
        rel_due = 0;
        stall_cnt = 0;
        stall_arm = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < 512; a++)
                mem[t][a] = 8'($urandom);

        tick();
        tick();
        do_reset();

        // 1: single packet, tuner 1, upper half, pid 0x123
        issue(3'b010, 3'b010, 12'h000, 12'h123, 12'h000);
        wait_done(2000);

        // 2: all three at once, then tuner 0 again while tuner 2 streams
        do_reset();
        issue(3'b111, 3'(($urandom)), 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        wait_mid(2, 60, 2000);
        issue(3'b001, 3'(($urandom)), 12'h0AB, 12'h000, 12'h000);
        wait_done(4000);
        check("ovf_none", ovf_o, m_ovf);

        // 3: five-clock FIFO full stall around byte 50
        stall_arm = 1;
        issue(3'b010, 3'b001, 12'h000, 12'h3C5, 12'h000);
        wait_done(2000);
        check("stall_hit", stall_arm, 0);

        // 4: flagb toggling every clock for a whole packet
        fmode = 2;
        issue(3'b001, 3'b001, 12'h7E1, 12'h000, 12'h000);
        wait_done(5000);
        fmode = 0;

        // 5: two request edges on tuner 2 while tuner 0 is busy
        issue(3'b001, 3'b000, 12'h111, 12'h000, 12'h000);
        repeat (8) tick();
        issue(3'b100, 3'b000, 12'h000, 12'h000, 12'hAAA);
        tick();
        issue(3'b100, 3'b100, 12'h000, 12'h000, 12'h555);
        wait_done(4000);
        check("ovf_tuner2", ovf_o, m_ovf);

        // Random batches with random backpressure
        for (int r = 0; r < 6; r++) begin
            fmode = int'($urandom_range(0, 1));
            issue(3'($urandom_range(1, 7)), 3'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
            wait_done(6000);
            check("ovf_sticky", ovf_o, m_ovf);
        end
        fmode = 0;

        // 6: reset at byte 100, then a clean packet
        issue(3'b010, 3'b000, 12'h000, 12'h246, 12'h000);
        wait_mid(1, 100, 2000);
        do_reset();
        issue(3'b100, 3'b000, 12'h000, 12'h000, 12'h9F0);
        wait_done(2000);
        check("ovf_after_rst", ovf_o, m_ovf);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
